adder_checker: RTL and testbench

Result-side monitor for a registered W-bit adder (ports clk, a, b, c_in, sum, c_out).
- Taps the operand bus, computes the expected {c_out, sum} and delays it through a LAT-stage pipeline aligned to the adder's output latency.
- Compares the expectation against the adder's actual outputs; reports per-beat mismatches, pass/error counts and a sticky error flag.
- Sits beside the adder in benches and on-board self-test builds, driven by the same clock.

---
 rtl/adder_checker.sv | 168 ++++++++++++++++
 tb/tb_adder_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// Result-side monitor for a registered W-bit adder: delays a+b+c_in by LAT cycles and checks sum/c_out.
// Optional macro ADDER_CHECKER_FIRST_ERR_EN adds first-failure capture outputs (operands and observed result).
module adder_checker #(
  parameter int W     = 16,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             c_in,
  input  logic [W-1:0]     sum,
  input  logic             c_out,
  output logic [W-1:0]     exp_sum,
  output logic             exp_c_out,
  output logic             mismatch,
  output logic             error_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  ,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b,
  output logic             first_c_in,
  output logic [W-1:0]     first_sum,
  output logic             first_c_out
`endif
);

  localparam int EW = W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [LAT-1:0]         vld_q;
  logic [LAT-1:0][EW-1:0] exp_q;
  logic [EW-1:0]          exp0;

  assign exp0 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

  // Only valid bits are reset; stale data behind a cleared valid is never looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_q[0] <= exp0;
    for (int i = 1; i < LAT; i++) exp_q[i] <= exp_q[i-1];
  end

  logic          tail_vld;
  logic [EW-1:0] tail_exp;
  logic          hit;

  assign tail_vld = vld_q[LAT-1];
  assign tail_exp = exp_q[LAT-1];
  assign hit      = (sum == tail_exp[W-1:0]) && (c_out == tail_exp[W]);

`ifdef ADDER_CHECKER_FIRST_ERR_EN
  // {c_in, a, b} follows the expectation so the failing operands are at hand at compare time.
  logic [LAT-1:0][2*W:0] opd_q;
  logic [2*W:0]          tail_opd;

  always_ff @(posedge clk) begin
    opd_q[0] <= {c_in, a, b};
    for (int i = 1; i < LAT; i++) opd_q[i] <= opd_q[i-1];
  end

  assign tail_opd = opd_q[LAT-1];

  logic [W-1:0] first_a_q, first_a_d, first_b_q, first_b_d, first_sum_q, first_sum_d;
  logic         first_c_in_q, first_c_in_d, first_c_out_q, first_c_out_d;
`endif

  logic [W-1:0]     exp_sum_q, exp_sum_d;
  logic             exp_c_out_q, exp_c_out_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] pass_q, pass_d, err_q, err_d;

  always_comb begin
    exp_sum_d   = exp_sum_q;
    exp_c_out_d = exp_c_out_q;
    mismatch_d  = 1'b0;
    sticky_d    = sticky_q;
    pass_d      = pass_q;
    err_d       = err_q;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    first_a_d     = first_a_q;
    first_b_d     = first_b_q;
    first_c_in_d  = first_c_in_q;
    first_sum_d   = first_sum_q;
    first_c_out_d = first_c_out_q;
`endif
    if (tail_vld) begin
      exp_sum_d   = tail_exp[W-1:0];
      exp_c_out_d = tail_exp[W];
      if (hit) begin
        if (!(&pass_q)) pass_d = pass_q + CNT_ONE;
      end else begin
        if (!(&err_q)) err_d = err_q + CNT_ONE;
        mismatch_d = 1'b1;
        sticky_d   = 1'b1;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
        if (!sticky_q) begin
          first_c_in_d  = tail_opd[2*W];
          first_a_d     = tail_opd[2*W-1:W];
          first_b_d     = tail_opd[W-1:0];
          first_sum_d   = sum;
          first_c_out_d = c_out;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_sum_q   <= '0;
      exp_c_out_q <= 1'b0;
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      pass_q      <= '0;
      err_q       <= '0;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
      first_a_q     <= '0;
      first_b_q     <= '0;
      first_c_in_q  <= 1'b0;
      first_sum_q   <= '0;
      first_c_out_q <= 1'b0;
`endif
    end else begin
      exp_sum_q   <= exp_sum_d;
      exp_c_out_q <= exp_c_out_d;
      mismatch_q  <= mismatch_d;
      sticky_q    <= sticky_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
      first_a_q     <= first_a_d;
      first_b_q     <= first_b_d;
      first_c_in_q  <= first_c_in_d;
      first_sum_q   <= first_sum_d;
      first_c_out_q <= first_c_out_d;
`endif
    end
  end

  assign exp_sum      = exp_sum_q;
  assign exp_c_out    = exp_c_out_q;
  assign mismatch     = mismatch_q;
  assign error_sticky = sticky_q;
  assign pass_count   = pass_q;
  assign err_count    = err_q;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  assign first_a     = first_a_q;
  assign first_b     = first_b_q;
  assign first_c_in  = first_c_in_q;
  assign first_sum   = first_sum_q;
  assign first_c_out = first_c_out_q;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: instance 0 LAT=1, instance 1 LAT=3, instance 2 LAT=1 with 4-bit counters.
module tb_adder_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        vld [3];
  logic [15:0] a   [3];
  logic [15:0] b   [3];
  logic        ci  [3];
  logic [15:0] s   [3];
  logic        co  [3];
  logic [15:0] es  [3];
  logic        ec  [3];
  logic        mm  [3];
  logic        st  [3];
  logic [15:0] pcnt [2];
  logic [15:0] ecnt [2];
  logic [3:0]  pcnt2, ecnt2;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  logic [15:0] fa [3];
  logic [15:0] fb [3];
  logic [15:0] fs [3];
  logic        fci [3];
  logic        fco [3];
`endif

  int checks = 0;
  int failures = 0;

  adder_checker #(.W(16), .LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .a(a[0]), .b(b[0]), .c_in(ci[0]),
    .sum(s[0]), .c_out(co[0]), .exp_sum(es[0]), .exp_c_out(ec[0]), .mismatch(mm[0]),
    .error_sticky(st[0]), .pass_count(pcnt[0]), .err_count(ecnt[0])
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    , .first_a(fa[0]), .first_b(fb[0]), .first_c_in(fci[0]), .first_sum(fs[0]), .first_c_out(fco[0])
`endif
  );

  adder_checker #(.W(16), .LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .a(a[1]), .b(b[1]), .c_in(ci[1]),
    .sum(s[1]), .c_out(co[1]), .exp_sum(es[1]), .exp_c_out(ec[1]), .mismatch(mm[1]),
    .error_sticky(st[1]), .pass_count(pcnt[1]), .err_count(ecnt[1])
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    , .first_a(fa[1]), .first_b(fb[1]), .first_c_in(fci[1]), .first_sum(fs[1]), .first_c_out(fco[1])
`endif
  );

  adder_checker #(.W(16), .LAT(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .a(a[2]), .b(b[2]), .c_in(ci[2]),
    .sum(s[2]), .c_out(co[2]), .exp_sum(es[2]), .exp_c_out(ec[2]), .mismatch(mm[2]),
    .error_sticky(st[2]), .pass_count(pcnt2), .err_count(ecnt2)
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    , .first_a(fa[2]), .first_b(fb[2]), .first_c_in(fci[2]), .first_sum(fs[2]), .first_c_out(fco[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  logic [16:0] e [10];
  logic [16:0] prev;
  bit   bv [10] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
  int   exp_pc;

  initial begin
    for (int k = 0; k < 3; k++) begin
      vld[k] = 0; a[k] = 0; b[k] = 0; ci[k] = 0; s[k] = 0; co[k] = 0;
    end

    // Reset held two cycles with random inputs
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        vld[k] = 1'($urandom); a[k] = 16'($urandom); b[k] = 16'($urandom);
        ci[k] = 1'($urandom); s[k] = 16'($urandom); co[k] = 1'($urandom);
      end
      step();
      for (int k = 0; k < 3; k++) begin
        chk("rst_exp_sum", 32'(es[k]), 0);
        chk("rst_exp_c_out", 32'(ec[k]), 0);
        chk("rst_mismatch", 32'(mm[k]), 0);
        chk("rst_sticky", 32'(st[k]), 0);
      end
      chk("rst_pass0", 32'(pcnt[0]), 0); chk("rst_err0", 32'(ecnt[0]), 0);
      chk("rst_pass1", 32'(pcnt[1]), 0); chk("rst_err1", 32'(ecnt[1]), 0);
      chk("rst_pass2", 32'(pcnt2), 0);   chk("rst_err2", 32'(ecnt2), 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) vld[k] = 0;
    step();
    chk("idle_mismatch0", 32'(mm[0]), 0);

    // Basic pass, LAT=1: 1+1+1 = 3
    vld[0] = 1; a[0] = 16'd1; b[0] = 16'd1; ci[0] = 1;
    step();
    vld[0] = 0; s[0] = 16'd3; co[0] = 0;
    step();
    chk("basic_exp_sum", 32'(es[0]), 32'd3);
    chk("basic_exp_c_out", 32'(ec[0]), 0);
    chk("basic_pass", 32'(pcnt[0]), 1);
    chk("basic_mismatch", 32'(mm[0]), 0);
    chk("basic_err", 32'(ecnt[0]), 0);

    // Carry/wrap: FFFF+1 = {1,0000}; DUT reports c_out=0
    vld[0] = 1; a[0] = 16'hFFFF; b[0] = 16'h0001; ci[0] = 0;
    step();
    vld[0] = 0; s[0] = 16'h0000; co[0] = 0;
    step();
    chk("wrap_exp_sum", 32'(es[0]), 0);
    chk("wrap_exp_c_out", 32'(ec[0]), 1);
    chk("wrap_mismatch", 32'(mm[0]), 1);
    chk("wrap_err", 32'(ecnt[0]), 1);
    chk("wrap_sticky", 32'(st[0]), 1);
    step();
    chk("wrap_mismatch_drop", 32'(mm[0]), 0);
    chk("wrap_sticky_hold", 32'(st[0]), 1);

    // Ten back-to-back passing beats; sticky must stay
    prev = '0;
    for (int i = 0; i <= 10; i++) begin
      vld[0] = (i < 10);
      a[0] = 16'(i * 16'h1800); b[0] = 16'h9000; ci[0] = 1'(i);
      s[0] = prev[15:0]; co[0] = prev[16];
      prev = add(a[0], b[0], ci[0]);
      step();
      if (i > 0) begin
        chk("stream1_sticky", 32'(st[0]), 1);
        chk("stream1_mismatch", 32'(mm[0]), 0);
      end
    end
    chk("stream1_pass", 32'(pcnt[0]), 11);
    chk("stream1_err", 32'(ecnt[0]), 1);

    // LAT=3 streaming: 4 beats, 2 idle, 1 beat; garbage sum on non-compare cycles
    exp_pc = 0;
    for (int t = 0; t < 10; t++) begin
      vld[1] = bv[t];
      a[1] = 16'(t * 16'h2345 + 7); b[1] = 16'(16'hE000 + t * 3); ci[1] = 1'(t);
      e[t] = add(a[1], b[1], ci[1]);
      if (t >= 3 && bv[t-3]) begin
        s[1] = e[t-3][15:0]; co[1] = e[t-3][16];
      end else begin
        s[1] = 16'hDEAD; co[1] = 1'b1;
      end
      step();
      if (t >= 3 && bv[t-3]) exp_pc++;
      chk("lat3_mismatch", 32'(mm[1]), 0);
      chk("lat3_pass_run", 32'(pcnt[1]), 32'(exp_pc));
    end
    chk("lat3_pass", 32'(pcnt[1]), 5);
    chk("lat3_exp_sum", 32'(es[1]), 32'(e[6][15:0]));
    chk("lat3_exp_c_out", 32'(ec[1]), 32'(e[6][16]));

    // Reset mid-flight, LAT=3: beat at N, rst at N+1, wrong sum at N+3
    vld[1] = 1; a[1] = 16'd1; b[1] = 16'd2; ci[1] = 0;
    step();
    vld[1] = 0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pass_clr", 32'(pcnt[1]), 0);
    step();
    s[1] = 16'h0BAD; co[1] = 1;
    step();
    chk("midrst_mismatch", 32'(mm[1]), 0);
    chk("midrst_err", 32'(ecnt[1]), 0);
    chk("midrst_pass", 32'(pcnt[1]), 0);
    step();
    chk("midrst_mismatch2", 32'(mm[1]), 0);
    chk("midrst_sticky", 32'(st[1]), 0);

    // Saturation with CNT_W=4: 20 good beats, then one bad one
    prev = '0;
    for (int i = 0; i <= 20; i++) begin
      vld[2] = 1;
      if (i < 20) begin
        a[2] = 16'(i * 7); b[2] = 16'(i * 1000); ci[2] = 1'(i);
      end else begin
        a[2] = 16'h1234; b[2] = 16'h4321; ci[2] = 1;
      end
      s[2] = prev[15:0]; co[2] = prev[16];
      prev = add(a[2], b[2], ci[2]);
      step();
      if (i == 15) chk("sat_pass_15", 32'(pcnt2), 15);
    end
    chk("sat_pass_hold", 32'(pcnt2), 15);
    chk("sat_err_zero", 32'(ecnt2), 0);
    vld[2] = 0; s[2] = 16'h5555; co[2] = 0;
    step();
    chk("sat_bad_mismatch", 32'(mm[2]), 1);
    chk("sat_bad_err", 32'(ecnt2), 1);
    chk("sat_bad_pass", 32'(pcnt2), 15);
    chk("sat_bad_sticky", 32'(st[2]), 1);
    chk("sat_bad_exp_sum", 32'(es[2]), 32'h5556);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    chk("first_a", 32'(fa[2]), 32'h1234);
    chk("first_b", 32'(fb[2]), 32'h4321);
    chk("first_c_in", 32'(fci[2]), 1);
    chk("first_sum", 32'(fs[2]), 32'h5555);
    chk("first_c_out", 32'(fco[2]), 0);
`endif
    // Second bad beat: counts, first_* must not move
    vld[2] = 1; a[2] = 16'd1; b[2] = 16'd1; ci[2] = 0;
    step();
    vld[2] = 0; s[2] = 16'd0; co[2] = 1;
    step();
    chk("sat_bad2_err", 32'(ecnt2), 2);
    chk("sat_bad2_mismatch", 32'(mm[2]), 1);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    chk("first_a_hold", 32'(fa[2]), 32'h1234);
    chk("first_sum_hold", 32'(fs[2]), 32'h5555);
`endif
    step();
    chk("sat_mismatch_drop", 32'(mm[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
